// File: rtl/bisqrt_bs2bin_acc.sv
// Window accumulator for the bipolar sqrt bitstream: counts ones over 2^WINLOG
// accepted bits and reports both the unsigned count and the signed bipolar value.
module bisqrt_bs2bin_acc #(
    parameter int unsigned WINLOG = 8,
    parameter int unsigned CNTW   = WINLOG + 1,
    parameter int unsigned BIW    = WINLOG + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  in_bit,
    input  logic                  in_valid,
    output logic                  busy,
    output logic                  out_valid,
    output logic [CNTW-1:0]       out_ones,
    output logic signed [BIW-1:0] out_bi
);

    localparam int unsigned WIN = 2 ** WINLOG;
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(WIN - 1);
    localparam logic [BIW-1:0]  BI_OFFSET = BIW'(WIN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CNTW-1:0] wcnt;
    logic [CNTW-1:0] acc;
    logic [CNTW-1:0] acc_sum;
    logic [BIW-1:0]  bi_val;

    // Count including the bit on the input this cycle, and its bipolar form.
    always_comb begin
        acc_sum = acc + CNTW'(in_bit);
        bi_val  = BIW'({acc_sum, 1'b0}) - BI_OFFSET;
    end

    // Results are registered on the edge that accepts the last window bit,
    // so they are visible together with out_valid during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_ones  <= '0;
            out_bi    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACC;
                        busy  <= 1'b1;
                        wcnt  <= '0;
                        acc   <= '0;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc  <= acc_sum;
                        wcnt <= wcnt + CNTW'(1);
                        if (wcnt == LAST_IDX) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            out_ones  <= acc_sum;
                            out_bi    <= bi_val;
                        end
                    end
                end
                DONE: begin
                    wcnt <= '0;
                    acc  <= '0;
                    if (cont) begin
                        state <= ACC;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bisqrt_bs2bin_acc.sv
// Randomized bench for bisqrt_bs2bin_acc: windows are scored against a plain
// ones-count model (ones = sum of accepted bits, bipolar = 2*ones - 2^WINLOG).
module tb_bisqrt_bs2bin_acc;

    localparam int unsigned WINLOG = 8;
    localparam int unsigned CNTW   = WINLOG + 1;
    localparam int unsigned BIW    = WINLOG + 2;
    localparam int          WIN    = 2 ** WINLOG;

    logic clk = 1'b0;
    logic rst, start, cont, in_bit, in_valid;
    logic                  busy, out_valid;
    logic [CNTW-1:0]       out_ones;
    logic signed [BIW-1:0] out_bi;

    int n_tests = 0;
    int n_fail  = 0;

    bisqrt_bs2bin_acc #(.WINLOG(WINLOG), .CNTW(CNTW), .BIW(BIW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cont     (cont),
        .in_bit   (in_bit),
        .in_valid (in_valid),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ones (out_ones),
        .out_bi   (out_bi)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one start-initiated window (mode 0=ones 1=zeros 2=alternating 3=random)
    // and report what the DUT showed; expected ones come from the bits actually accepted.
    task automatic run_window(input int mode, input bit gaps,
                              output int exp_ones, output int cycles, output bit early,
                              output logic v_end, output logic b_end, output logic v_after,
                              output logic [CNTW-1:0] o_ones, output logic signed [BIW-1:0] o_bi,
                              output logic [CNTW-1:0] hold_ones);
        int  accepted;
        bit  vbit;
        accepted = 0;
        exp_ones = 0;
        cycles   = 0;
        early    = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        step();
        start = 1'b0;
        while (accepted < WIN && cycles < 4 * WIN) begin
            vbit = gaps ? cycles[0] : 1'b1;
            in_valid = vbit;
            case (mode)
                0:       in_bit = 1'b1;
                1:       in_bit = 1'b0;
                2:       in_bit = (accepted % 2 == 0);
                default: in_bit = 1'($urandom_range(0, 1));
            endcase
            if (!vbit) in_bit = 1'b1;
            if (vbit) begin
                exp_ones += int'(in_bit);
                accepted++;
            end
            step();
            cycles++;
            if (accepted < WIN && out_valid) early = 1'b1;
        end
        v_end    = out_valid;
        b_end    = busy;
        o_ones   = out_ones;
        o_bi     = out_bi;
        in_valid = 1'b0;
        step();
        v_after   = out_valid;
        hold_ones = out_ones;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || out_ones !== '0 || out_bi !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d: busy=%b valid=%b ones=%0d bi=%0d, want all 0",
                         i, busy, out_valid, out_ones, out_bi);
            end
        end
    endtask

    task automatic test_all_ones();
        int eo, cyc; bit early; logic ve, be, va;
        logic [CNTW-1:0] oo, ho; logic signed [BIW-1:0] ob;
        run_window(0, 1'b0, eo, cyc, early, ve, be, va, oo, ob, ho);
        n_tests++;
        if (ve !== 1'b1 || be !== 1'b0 || va !== 1'b0 || early || cyc != WIN) begin
            n_fail++;
            $display("FAIL all_ones_timing: valid=%b busy=%b valid_next=%b early=%0d cycles=%0d, want 1 0 0 0 %0d",
                     ve, be, va, early, cyc, WIN);
        end
        n_tests++;
        if (oo !== CNTW'(WIN) || int'(ob) != WIN || eo != WIN) begin
            n_fail++;
            $display("FAIL all_ones_value: ones=%0d bi=%0d, want %0d %0d", oo, ob, WIN, WIN);
        end
    endtask

    task automatic test_alternating();
        int eo, cyc; bit early; logic ve, be, va;
        logic [CNTW-1:0] oo, ho; logic signed [BIW-1:0] ob;
        run_window(2, 1'b0, eo, cyc, early, ve, be, va, oo, ob, ho);
        n_tests++;
        if (ve !== 1'b1 || oo !== CNTW'(WIN / 2) || int'(ob) != 0 || ho !== oo) begin
            n_fail++;
            $display("FAIL alternating: valid=%b ones=%0d bi=%0d held=%0d, want 1 %0d 0 %0d",
                     ve, oo, ob, ho, WIN / 2, WIN / 2);
        end
    endtask

    task automatic test_all_zeros();
        int eo, cyc; bit early; logic ve, be, va;
        logic [CNTW-1:0] oo, ho; logic signed [BIW-1:0] ob;
        run_window(1, 1'b0, eo, cyc, early, ve, be, va, oo, ob, ho);
        n_tests++;
        if (ve !== 1'b1 || oo !== '0 || int'(ob) != -WIN) begin
            n_fail++;
            $display("FAIL all_zeros: valid=%b ones=%0d bi=%0d, want 1 0 %0d", ve, oo, ob, -WIN);
        end
    endtask

    task automatic test_gaps();
        int eo, cyc; bit early; logic ve, be, va;
        logic [CNTW-1:0] oo, ho; logic signed [BIW-1:0] ob;
        run_window(0, 1'b1, eo, cyc, early, ve, be, va, oo, ob, ho);
        n_tests++;
        if (ve !== 1'b1 || early || cyc != 2 * WIN) begin
            n_fail++;
            $display("FAIL gaps_timing: valid=%b early=%0d cycles=%0d, want 1 0 %0d", ve, early, cyc, 2 * WIN);
        end
        n_tests++;
        if (oo !== CNTW'(WIN) || int'(ob) != WIN) begin
            n_fail++;
            $display("FAIL gaps_value: ones=%0d bi=%0d, want %0d %0d", oo, ob, WIN, WIN);
        end
    endtask

    task automatic test_random();
        int eo, cyc; bit early; logic ve, be, va;
        logic [CNTW-1:0] oo, ho; logic signed [BIW-1:0] ob;
        for (int w = 0; w < 3; w++) begin
            run_window(3, w[0], eo, cyc, early, ve, be, va, oo, ob, ho);
            n_tests++;
            if (ve !== 1'b1 || be !== 1'b0 || early || oo !== CNTW'(eo) || int'(ob) != 2 * eo - WIN) begin
                n_fail++;
                $display("FAIL random_w%0d: valid=%b busy=%b early=%0d ones=%0d bi=%0d, want 1 0 0 %0d %0d",
                         w, ve, be, early, oo, ob, eo, 2 * eo - WIN);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t, np;
        int tp[2];
        logic [CNTW-1:0] vals[2];
        t = 0; np = 0;
        tp[0] = 0; tp[1] = 0;
        vals[0] = '0; vals[1] = '0;
        cont = 1'b1; start = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        step();
        start = 1'b0;
        while (np < 2 && t < 1000) begin
            if (np == 1 && t == tp[0] + 10) cont = 1'b0;
            start  = (t == 100 || t == 400);
            in_bit = (np == 0) || (np == 1 && t == tp[0]);
            step();
            t++;
            if (out_valid) begin
                tp[np]   = t;
                vals[np] = out_ones;
                np++;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (np != 2 || tp[1] - tp[0] != WIN + 1 || tp[0] != WIN) begin
            n_fail++;
            $display("FAIL cont_period: pulses=%0d first=%0d gap=%0d, want 2 %0d %0d",
                     np, tp[0], tp[1] - tp[0], WIN, WIN + 1);
        end
        n_tests++;
        if (vals[0] !== CNTW'(WIN) || vals[1] !== '0) begin
            n_fail++;
            $display("FAIL cont_values: first=%0d second=%0d, want %0d 0", vals[0], vals[1], WIN);
        end
        step();
        step();
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_stop: busy=%b valid=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        int eo, cyc; bit early, seen; logic ve, be, va;
        logic [CNTW-1:0] oo, ho; logic signed [BIW-1:0] ob;
        seen = 1'b0;
        start = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            in_bit = 1'($urandom_range(0, 1));
            step();
            if (out_valid) seen = 1'b1;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_ones !== '0 || out_bi !== '0 || seen) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b valid=%b ones=%0d bi=%0d early=%0d, want all 0",
                     busy, out_valid, out_ones, out_bi, seen);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid || busy) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL mid_reset_idle: activity=%0d, want 0", seen);
        end
        run_window(3, 1'b0, eo, cyc, early, ve, be, va, oo, ob, ho);
        n_tests++;
        if (ve !== 1'b1 || early || oo !== CNTW'(eo) || int'(ob) != 2 * eo - WIN) begin
            n_fail++;
            $display("FAIL post_reset_window: valid=%b early=%0d ones=%0d bi=%0d, want 1 0 %0d %0d",
                     ve, early, oo, ob, eo, 2 * eo - WIN);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0; in_bit = 1'b0; in_valid = 1'b0;
        test_reset();
        test_all_ones();
        test_alternating();
        test_all_zeros();
        test_gaps();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
